regfile_fwd_sb: RTL and testbench



---
 rtl/regfile_fwd_sb_pkg.sv | 9 +
 rtl/regfile_fwd_sb_if.sv | 27 ++
 rtl/regfile_fwd_sb_busy_table.sv | 27 ++
 rtl/regfile_fwd_sb.sv | 67 ++++++
 tb/tb_regfile_fwd_sb.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_fwd_sb_pkg.sv
// Shared constants and types for the register file slice (default 64 x 32 configuration).
package regfile_pkg;
  localparam int RF_WIDTH = 64;
  localparam int RF_DEPTH = 32;
  localparam int RF_ZERO  = 31;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] reg_data_t;
endpackage

// File: rtl/regfile_fwd_sb_if.sv
// Decode/writeback bundle: write port, issue port and NREAD read ports.
interface regfile_fwd_sb_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = $clog2(RF_DEPTH),
  parameter int NREAD = 2
);
  logic                        RegWrite;
  logic [AW-1:0]               WriteRegister;
  logic [WIDTH-1:0]            WriteData;
  logic [NREAD-1:0][AW-1:0]    ReadRegister;
  logic [NREAD-1:0][WIDTH-1:0] ReadData;
  logic [NREAD-1:0]            ReadBusy;
  logic                        Issue;
  logic [AW-1:0]               IssueRegister;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister, Issue, IssueRegister,
    input  ReadData, ReadBusy
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister, Issue, IssueRegister,
    output ReadData, ReadBusy
  );
endinterface

// File: rtl/regfile_fwd_sb_busy_table.sv
// Per-register busy scoreboard: set on issue, clear on writeback, set wins on a tie.
module busy_table #(
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = DEPTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  output logic [DEPTH-1:0] busy_vec
);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      // NOTE: the set is written after the clear, so with non-blocking assignment the
      // later update to the same bit wins -- that ordering is the set-over-clear priority.
      if (clr_en && clr_idx != ZERO_IDX) busy_vec[clr_idx] <= 1'b0;
      if (set_en && set_idx != ZERO_IDX) busy_vec[set_idx] <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_fwd_sb.sv
// Register file with hardwired zero register, write-to-read forwarding and busy scoreboard.
module regfile_fwd_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = DEPTH - 1
) (
  input logic             clk,
  input logic             reset,
  regfile_fwd_sb_if.slave bus
);
  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [WIDTH-1:0]            regs [DEPTH];
  logic [DEPTH-1:0]            busy_vec;
  logic [NREAD-1:0][WIDTH-1:0] rd_data;
  logic [NREAD-1:0]            rd_busy;
  logic                        fwd_en;

  busy_table #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_busy_table (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.Issue),
    .set_idx  (bus.IssueRegister),
    .clr_en   (bus.RegWrite),
    .clr_idx  (bus.WriteRegister),
    .busy_vec (busy_vec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole array is cleared because reads of any register must show 0
      // after reset; this forces flops rather than a RAM macro for the storage.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (bus.RegWrite && bus.WriteRegister != ZERO_IDX) begin
      regs[bus.WriteRegister] <= bus.WriteData;
    end
  end

  // Forwarding is suppressed during reset so reads show the (cleared) storage.
  assign fwd_en = bus.RegWrite && !reset;

  always_comb begin
    // NOTE: every output gets a value on every path before the overrides, so no latch.
    for (int p = 0; p < NREAD; p++) begin
      rd_data[p] = regs[bus.ReadRegister[p]];
      rd_busy[p] = busy_vec[bus.ReadRegister[p]];
      if (bus.ReadRegister[p] == ZERO_IDX) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if (fwd_en && bus.WriteRegister == bus.ReadRegister[p]) begin
        rd_data[p] = bus.WriteData;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign bus.ReadData = rd_data;
  assign bus.ReadBusy = rd_busy;
endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Drives the default (64x32, 2 ports) and a 32x16, 3-port build with identical stimulus.
module tb_regfile_fwd_sb;
  logic clk = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] Z = 5'd31;  // symbolic zero register: 31 on big, 15 on small

  typedef struct {
    string            name;
    bit               chk;
    bit               rst;
    bit               we;
    logic [4:0]       widx;
    logic [63:0]      wdata;
    bit               iss;
    logic [4:0]       iidx;
    logic [2:0][4:0]  r;
    logic [2:0][63:0] ed;   // expected data, big build
    logic [2:0][31:0] eds;  // expected data, small build
    logic [2:0]       eb;   // expected busy, both builds
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  regfile_fwd_sb_if #(.WIDTH(64), .AW(5), .NREAD(2)) b_if ();
  regfile_fwd_sb_if #(.WIDTH(32), .AW(4), .NREAD(3)) s_if ();

  regfile_fwd_sb u_big (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  regfile_fwd_sb #(
    .WIDTH    (32),
    .DEPTH    (16),
    .NREAD    (3),
    .ZERO_REG (15)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (s_if.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] smap(logic [4:0] i);
    return (i == Z) ? 4'd15 : i[3:0];
  endfunction

  function automatic vec_t mk(string name, bit chk, bit rst, bit we, logic [4:0] widx,
                              logic [63:0] wdata, bit iss, logic [4:0] iidx,
                              logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                              logic [63:0] d0, logic [63:0] d1, logic [63:0] d2,
                              logic [2:0] eb);
    vec_t v;
    v.name = name; v.chk = chk; v.rst = rst; v.we = we; v.widx = widx; v.wdata = wdata;
    v.iss = iss; v.iidx = iidx;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
    v.eds[0] = d0[31:0]; v.eds[1] = d1[31:0]; v.eds[2] = d2[31:0];
    v.eb = eb;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    reset              = v.rst;
    b_if.RegWrite      = v.we;
    b_if.WriteRegister = v.widx;
    b_if.WriteData     = v.wdata;
    b_if.Issue         = v.iss;
    b_if.IssueRegister = v.iidx;
    s_if.RegWrite      = v.we;
    s_if.WriteRegister = smap(v.widx);
    s_if.WriteData     = v.wdata[31:0];
    s_if.Issue         = v.iss;
    s_if.IssueRegister = smap(v.iidx);
    for (int p = 0; p < 2; p++) b_if.ReadRegister[p] = v.r[p];
    for (int p = 0; p < 3; p++) s_if.ReadRegister[p] = smap(v.r[p]);
  endtask

  task automatic compare_front();
    vec_t e;
    e = sb_q.pop_front();
    if (e.chk) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("%s big data%0d", e.name, p), b_if.ReadData[p], e.ed[p]);
        check($sformatf("%s big busy%0d", e.name, p), {63'd0, b_if.ReadBusy[p]}, {63'd0, e.eb[p]});
      end
      for (int p = 0; p < 3; p++) begin
        check($sformatf("%s small data%0d", e.name, p), {32'd0, s_if.ReadData[p]}, {32'd0, e.eds[p]});
        check($sformatf("%s small busy%0d", e.name, p), {63'd0, s_if.ReadBusy[p]}, {63'd0, e.eb[p]});
      end
    end
  endtask

  // One vector per cycle: drive just after the edge, compare at the falling edge.
  task automatic step(vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    sb_q.push_back(v);
    @(negedge clk);
    compare_front();
  endtask

  function automatic logic [63:0] pat(int i);
    return {16'hC0DE, 16'(i), 32'h1000_0000 + 32'(i) * 32'h11};
  endfunction

  initial begin
    vec_t v;
    logic [63:0] v3 = 64'h0123_4567_89AB_CDEF;
    logic [63:0] ones = '1;

    //            name            chk rst we widx wdata      iss iidx  r0 r1 r2   d0     d1     d2    busy(p2..p0)
    tbl.push_back(mk("reset",        0, 1, 0, 0, 0,          0, 0,    0, 5, Z,  0,     0,     0,    3'b000));
    tbl.push_back(mk("rst_read",     1, 0, 0, 0, 0,          0, 0,    0, 5, Z,  0,     0,     0,    3'b000));
    tbl.push_back(mk("wr_x3_fwd",    1, 0, 1, 3, v3,         0, 0,    3, 3, 0,  v3,    v3,    0,    3'b000));
    tbl.push_back(mk("wr_zero",      1, 0, 1, Z, ones,       0, 0,    3, 3, Z,  v3,    v3,    0,    3'b000));
    tbl.push_back(mk("rd_zero",      1, 0, 1, 7, 64'h11,     0, 0,    Z, Z, Z,  0,     0,     0,    3'b000));
    tbl.push_back(mk("fwd_x7",       1, 0, 1, 7, 64'h22,     0, 0,    7, 8, 7,  'h22,  0,     'h22, 3'b000));
    tbl.push_back(mk("hold_x7",      1, 0, 0, 0, 0,          0, 0,    7, 8, Z,  'h22,  0,     0,    3'b000));
    tbl.push_back(mk("issue_x9",     1, 0, 0, 0, 0,          1, 9,    9, 9, 9,  0,     0,     0,    3'b000));
    tbl.push_back(mk("busy_x9",      1, 0, 0, 0, 0,          0, 0,    9, 9, 0,  0,     0,     0,    3'b011));
    tbl.push_back(mk("wr_x9_fwd",    1, 0, 1, 9, 64'h5,      0, 0,    9, 9, Z,  5,     5,     0,    3'b000));
    tbl.push_back(mk("x9_clear",     1, 0, 0, 0, 0,          0, 0,    9, 9, 9,  5,     5,     5,    3'b000));
    tbl.push_back(mk("iss_wr_x10",   1, 0, 1, 10, 64'hAB,    1, 10,   10, 10, 10, 'hAB, 'hAB, 'hAB, 3'b000));
    tbl.push_back(mk("iss_zero",     1, 0, 0, 0, 0,          1, Z,    10, Z, 10, 'hAB, 0,    'hAB, 3'b101));
    tbl.push_back(mk("zero_notbusy", 1, 0, 1, 5, 64'h55,     1, 4,    Z, 5, 4,  0,     'h55,  0,    3'b000));
    tbl.push_back(mk("wr_x4",        1, 0, 1, 4, 64'hAA,     1, 9,    4, 5, Z,  'hAA,  'h55,  0,    3'b000));
    tbl.push_back(mk("iss_x4",       1, 0, 0, 0, 0,          1, 4,    4, 9, 5,  'hAA,  5,     'h55, 3'b010));
    tbl.push_back(mk("both_busy",    1, 0, 0, 0, 0,          0, 0,    4, 9, 10, 'hAA,  5,     'hAB, 3'b111));
    tbl.push_back(mk("rst_mid",      1, 1, 1, 4, 64'hBB,     1, 3,    4, 9, Z,  'hAA,  5,     0,    3'b011));
    tbl.push_back(mk("after_rst",    1, 0, 0, 0, 0,          0, 0,    4, 9, 3,  0,     0,     0,    3'b000));
    tbl.push_back(mk("wr_after_rst", 1, 0, 1, 9, 64'h77,     0, 0,    9, 3, 7,  'h77,  0,     0,    3'b000));
    tbl.push_back(mk("x9_held",      1, 0, 0, 0, 0,          0, 0,    9, Z, 9,  'h77,  0,     'h77, 3'b000));

    for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

    // Fill indices 0..15 (15 is the small build's zero register), forwarded on ports 0/1.
    for (int i = 0; i < 16; i++) begin
      v = mk($sformatf("fill%0d", i), 1, 0, 1, 5'(i), pat(i), 0, 0,
             5'(i), 5'(i), Z, pat(i), pat(i), 0, 3'b000);
      if (i == 15) begin
        v.eds[0] = '0;
        v.eds[1] = '0;
      end
      step(v);
    end

    // Read everything back from storage.
    for (int i = 0; i < 16; i++) begin
      v = mk($sformatf("readback%0d", i), 1, 0, 0, 0, 0, 0, 0,
             5'(i), Z, 5'(15 - i), pat(i), 0, pat(15 - i), 3'b000);
      if (i == 15) v.eds[0] = '0;
      if (i == 0)  v.eds[2] = '0;
      step(v);
    end

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
